// File: rtl/seq_digit_comparator.sv
// -----------------------------------------------------------------------------
// seq_digit_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared one
// DIGIT-bit slice per clock, most-significant slice first. The comparison
// stops at the first slice that differs. If every slice matches, the cascade
// inputs (cin_e/cin_l/cin_g) are copied to the result unchanged, so several
// comparators can be chained.
//
// Optional feature macro: SEQCMP_SIGNED_EN
//   When defined, a signed_mode input is added. With signed_mode=1, the sign
//   bits of both operands are inverted as they are latched. This gives
//   two's-complement ordering and does not change latency.
//
// Parameters:
//   WIDTH        operand width; must be a multiple of DIGIT
//   DIGIT        slice width compared per cycle
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request a comparison (accepted in IDLE or DONE only)
//   a, b         operands, sampled on the accepting edge
//   cin_e/l/g    cascade inputs, sampled on the accepting edge
//   signed_mode  two's-complement compare (SEQCMP_SIGNED_EN builds only)
//   busy         high while comparing
//   done         one-cycle pulse when a new result is valid
//   eq, lt, gt   result flags (A==B, A<B, A>B)
//   digits_used  number of slices examined for the last result
// -----------------------------------------------------------------------------
module seq_digit_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    input  logic                                cin_e,
    input  logic                                cin_l,
    input  logic                                cin_g,
`ifdef SEQCMP_SIGNED_EN
    input  logic                                signed_mode,
`endif
    output logic                                busy,
    output logic                                done,
    output logic                                eq,
    output logic                                lt,
    output logic                                gt,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]    digits_used
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Refuse to build when the operand does not split into whole slices.
    if ((WIDTH % DIGIT) != 0) begin : g_width_check
        $error("seq_digit_comparator: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              cin_e_r;
    logic              cin_l_r;
    logic              cin_g_r;
    logic [IW-1:0]     idx_r;
    logic [CW-1:0]     count_r;

    logic [WIDTH-1:0]  sign_flip_s;
    logic [DIGIT-1:0]  slice_a_s;
    logic [DIGIT-1:0]  slice_b_s;
    logic [CW-1:0]     count_inc_s;

    // Extract slice i (slice 0 = least significant) from an operand.
    function automatic logic [DIGIT-1:0] slice_of(input logic [WIDTH-1:0] v,
                                                  input logic [IW-1:0]    i);
        logic [WIDTH-1:0] sh;
        sh = v >> (int'(i) * DIGIT);
        return sh[DIGIT-1:0];
    endfunction

    // Sign-bit inversion mask applied at latch time. Flipping both MSBs maps
    // two's-complement order onto unsigned order for the top slice only.
    always_comb begin
        sign_flip_s = {WIDTH{1'b0}};
`ifdef SEQCMP_SIGNED_EN
        sign_flip_s[WIDTH-1] = signed_mode;
`endif
    end

    // Current slice pair and the slice count including this cycle.
    always_comb begin
        slice_a_s   = slice_of(a_r, idx_r);
        slice_b_s   = slice_of(b_r, idx_r);
        count_inc_s = count_r + CW'(1'b1);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            cin_e_r     <= 1'b0;
            cin_l_r     <= 1'b0;
            cin_g_r     <= 1'b0;
            idx_r       <= {IW{1'b0}};
            count_r     <= {CW{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            eq          <= 1'b0;
            lt          <= 1'b0;
            gt          <= 1'b0;
            digits_used <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a ^ sign_flip_s;
                        b_r     <= b ^ sign_flip_s;
                        cin_e_r <= cin_e;
                        cin_l_r <= cin_l;
                        cin_g_r <= cin_g;
                        idx_r   <= IW'(NDIG - 1);
                        count_r <= {CW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= ST_CMP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    // start is deliberately ignored here; operands stay latched.
                    count_r <= count_inc_s;
                    if (slice_a_s != slice_b_s) begin
                        eq          <= 1'b0;
                        lt          <= (slice_a_s < slice_b_s);
                        gt          <= (slice_a_s > slice_b_s);
                        digits_used <= count_inc_s;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_r     <= ST_DONE;
                    end else if (idx_r == {IW{1'b0}}) begin
                        // All slices equal: cascade bits pass through unchecked.
                        eq          <= cin_e_r;
                        lt          <= cin_l_r;
                        gt          <= cin_g_r;
                        digits_used <= count_inc_s;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        idx_r <= idx_r - IW'(1'b1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_digit_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_digit_comparator
//
// Self-checking bench for seq_digit_comparator (WIDTH=16, DIGIT=4). It runs
// a table of directed vectors, then hand-written multi-cycle sequences
// (back-to-back start and reset during a comparison), then randomized
// operands. Expected results for the random operands come from a reference
// model based on integer ordering.
// -----------------------------------------------------------------------------
module tb_seq_digit_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin_e;
    logic        cin_l;
    logic        cin_g;
`ifdef SEQCMP_SIGNED_EN
    logic        signed_mode;
`endif
    logic        busy;
    logic        done;
    logic        eq;
    logic        lt;
    logic        gt;
    logic [2:0]  digits_used;

    int n_checks = 0;
    int n_fail   = 0;

    seq_digit_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .cin_e       (cin_e),
        .cin_l       (cin_l),
        .cin_g       (cin_g),
`ifdef SEQCMP_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt),
        .digits_used (digits_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        ce, cl, cg;
        logic        xe, xl, xg;
        int          xk;
        bit          repulse;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference model: the result comes from integer ordering. The slice
    // count comes from the position of the highest differing bit.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb,
                         input logic ce, input logic cl, input logic cg, input logic sm,
                         output logic xe, output logic xl, output logic xg, output int xk);
        logic [15:0] d;
        int p;
        d = ma ^ mb;
        if (d == 16'd0) begin
            xe = ce; xl = cl; xg = cg; xk = NDIG;
        end else begin
            p = 0;
            for (int i = 0; i < 16; i++) if (d[i]) p = i;
            xk = NDIG - (p / DIGIT);
            xe = 1'b0;
            if (sm) begin
                xl = ($signed(ma) < $signed(mb));
                xg = ($signed(ma) > $signed(mb));
            end else begin
                xl = (ma < mb);
                xg = (ma > mb);
            end
        end
    endtask

    // Start one comparison, then check acceptance, latency, result and hold.
    task automatic run_cmp(input string nm, input logic [15:0] ta, input logic [15:0] tbv,
                           input logic ce, input logic cl, input logic cg, input logic sm,
                           input logic xe, input logic xl, input logic xg, input int xk,
                           input bit rp);
        int cyc;
        @(negedge clk);
        a = ta; b = tbv; cin_e = ce; cin_l = cl; cin_g = cg;
`ifdef SEQCMP_SIGNED_EN
        signed_mode = sm;
`else
        if (sm) $display("note: signed_mode requested without SEQCMP_SIGNED_EN");
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_accept_busy"}, busy, 1);
        chk({nm, "_accept_done"}, done, 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 2 * NDIG + 4) begin
            if (rp && cyc == 1) begin
                // Re-pulse start mid-compare with different operands.
                start = 1'b1; a = ~ta; b = ta;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk({nm, "_latency"}, cyc, xk);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_busy_low"}, busy, 0);
        chk({nm, "_eqltgt"}, {eq, lt, gt}, {xe, xl, xg});
        chk({nm, "_digits_used"}, digits_used, xk);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, done, 0);
        chk({nm, "_hold"}, {eq, lt, gt, digits_used}, {xe, xl, xg, 3'(xk)});
    endtask

    initial begin
        logic        re, rl, rg, rsm, saw_done;
        logic [15:0] ra, rb;
        int          rk;

        vecs[0] = '{16'hC4A0, 16'h44A0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[1] = '{16'h0107, 16'h0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1};
        vecs[2] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b0};
        vecs[3] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0};
        vecs[5] = '{16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b0};
        vecs[6] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vecs[7] = '{16'hFFF1, 16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0};
        vecs[8] = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = 16'd0; b = 16'd0;
        cin_e = 1'b0; cin_l = 1'b0; cin_g = 1'b0;
`ifdef SEQCMP_SIGNED_EN
        signed_mode = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, eq, lt, gt, digits_used}, 8'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_cmp($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].ce, vecs[i].cl,
                    vecs[i].cg, 1'b0, vecs[i].xe, vecs[i].xl, vecs[i].xg, vecs[i].xk,
                    vecs[i].repulse);
        end

        // Back-to-back: start stays high through DONE with new operands.
        @(negedge clk);
        a = 16'hC4A0; b = 16'h44A0; cin_e = 1'b0; cin_l = 1'b0; cin_g = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        a = 16'h0001; b = 16'h0002;
        @(posedge clk); #1;
        chk("b2b_first_done", done, 1);
        chk("b2b_first_result", {eq, lt, gt, digits_used}, {3'b001, 3'd1});
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_accept", {busy, done}, 2'b10);
        rk = 0;
        while (done !== 1'b1 && rk < 12) begin
            @(posedge clk); #1;
            rk++;
        end
        chk("b2b_second_latency", rk, 4);
        chk("b2b_second_result", {eq, lt, gt, digits_used}, {3'b010, 3'd4});
        @(posedge clk); #1;

        // Reset during the second CMP cycle discards the partial compare.
        @(negedge clk);
        a = 16'h0107; b = 16'h0110; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_busy_before", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_outputs", {busy, done, eq, lt, gt, digits_used}, 8'd0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("rst_mid_no_done", {saw_done, busy}, 2'b00);

`ifdef SEQCMP_SIGNED_EN
        run_cmp("signed_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b0, 1'b1, 1'b0, 1, 1'b0);
        run_cmp("unsigned_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b1, 1, 1'b0);
`endif

        // Randomized operands vs. reference model
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = ra;
                2: rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                default: rb = ra ^ (16'($urandom) & 16'h00FF);
            endcase
            re = 1'($urandom); rl = 1'($urandom); rg = 1'($urandom);
`ifdef SEQCMP_SIGNED_EN
            rsm = 1'($urandom);
`else
            rsm = 1'b0;
`endif
            model(ra, rb, re, rl, rg, rsm, re, rl, rg, rk);
            run_cmp($sformatf("rand%0d", n), ra, rb, re, rl, rg, rsm, re, rl, rg, rk, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
